// File: rtl/aoi22_cell_checker_if.sv
// aoi22_cell_checker_if: control, result and CUT pin bundle for aoi22_cell_checker
interface aoi22_cell_checker_if;
    logic start;
    logic cut_zn;
    logic A1, A2, B1, B2;
    logic busy, done, pass;
    logic [4:0] err_count;
    logic first_fail_valid;
    logic [3:0] first_fail_idx;
    logic obs_valid;
    logic [3:0] obs_idx;
    logic obs_zn, obs_mismatch;
    modport slave (
        input start, cut_zn,
        output A1, A2, B1, B2, busy, done, pass, err_count, first_fail_valid, first_fail_idx,
        output obs_valid, obs_idx, obs_zn, obs_mismatch
    );
    modport master (
        output start, cut_zn,
        input A1, A2, B1, B2, busy, done, pass, err_count, first_fail_valid, first_fail_idx,
        input obs_valid, obs_idx, obs_zn, obs_mismatch
    );
endinterface

// File: rtl/aoi22_cell_checker.sv
// aoi22_cell_checker: drives all 16 input patterns into a 4-input cell and checks ZN against a truth table
module aoi22_cell_checker #(
    parameter logic [15:0] TRUTH_TABLE = 16'h0777,
    parameter int SETTLE_CYCLES = 2
) (
    input logic CK,
    input logic RN,
    aoi22_cell_checker_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;
    logic [3:0] idx_q, idx_d, cnt_q, cnt_d, ffi_q, ffi_d, oidx_q, oidx_d;
    logic [4:0] err_q, err_d;
    logic busy_q, busy_d, done_q, done_d, pass_q, pass_d, ffv_q, ffv_d;
    logic ov_q, ov_d, oz_q, oz_d, om_q, om_d;
    logic mis, sample;
    assign mis = bus.cut_zn !== TRUTH_TABLE[idx_q];
    assign sample = state_q == RUN && cnt_q == 4'(SETTLE_CYCLES);
    always_comb begin
        state_d = state_q;
        idx_d = idx_q;
        cnt_d = cnt_q;
        err_d = err_q;
        ffv_d = ffv_q;
        ffi_d = ffi_q;
        busy_d = busy_q;
        done_d = done_q;
        pass_d = pass_q;
        ov_d = 1'b0;
        oidx_d = oidx_q;
        oz_d = oz_q;
        om_d = om_q;
        if (state_q != RUN && bus.start) begin
            state_d = RUN;
            idx_d = '0;
            cnt_d = '0;
            err_d = '0;
            ffv_d = 1'b0;
            ffi_d = '0;
            busy_d = 1'b1;
            done_d = 1'b0;
            pass_d = 1'b0;
        end else if (state_q == RUN) begin
            cnt_d = cnt_q + 4'd1;
            if (sample) begin
                ov_d = 1'b1;
                oidx_d = idx_q;
                oz_d = bus.cut_zn;
                om_d = mis;
                err_d = err_q + 5'(mis);
                ffv_d = ffv_q | mis;
                ffi_d = (mis && !ffv_q) ? idx_q : ffi_q;
                cnt_d = '0;
                idx_d = (idx_q == 4'd15) ? 4'd0 : idx_q + 4'd1;
                if (idx_q == 4'd15) begin
                    state_d = DONE;
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    pass_d = err_d == 5'd0;
                end
            end
        end
    end
    always_ff @(posedge CK) begin
        if (!RN) begin
            state_q <= IDLE;
            idx_q <= '0;
            cnt_q <= '0;
            err_q <= '0;
            ffv_q <= 1'b0;
            ffi_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
            ov_q <= 1'b0;
            oidx_q <= '0;
            oz_q <= 1'b0;
            om_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q <= idx_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
            ffv_q <= ffv_d;
            ffi_q <= ffi_d;
            busy_q <= busy_d;
            done_q <= done_d;
            pass_q <= pass_d;
            ov_q <= ov_d;
            oidx_q <= oidx_d;
            oz_q <= oz_d;
            om_q <= om_d;
        end
    end
    assign {bus.A1, bus.A2, bus.B1, bus.B2} = idx_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.pass = pass_q;
    assign bus.err_count = err_q;
    assign bus.first_fail_valid = ffv_q;
    assign bus.first_fail_idx = ffi_q;
    assign bus.obs_valid = ov_q;
    assign bus.obs_idx = oidx_q;
    assign bus.obs_zn = oz_q;
    assign bus.obs_mismatch = om_q;
endmodule

// File: doc/aoi22_cell_checker.md
Name: aoi22_cell_checker

Overview:
- Synthesizable self-checking driver and response checker for a 4-input standard cell (A1, A2, B1, B2 -> ZN), AOI22 by default.
- On start, it applies all 16 input patterns in ascending order {A1,A2,B1,B2} = 0000..1111, waits a settle time, and samples ZN from the cell under test (CUT).
- It compares each sample against a parameterized truth table, then reports mismatch count, first failing pattern and pass/fail.
- Sits beside a cell instance in on-chip cell-characterisation and BIST harnesses.

Parameters:
- TRUTH_TABLE, 16'h0777: expected ZN per pattern index; bit i = expected ZN for {A1,A2,B1,B2} = i. The default is AOI22: ZN = !((A1&A2)|(B1&B2)).
- SETTLE_CYCLES, 2: clock edges between loading a pattern and sampling ZN. Legal range 1..15.

Ports:
- CK, input, 1: clock, rising edge.
- RN, input, 1: synchronous active-low reset, sampled on CK rising edge.
- start, input, 1: begin a run. Honoured only in IDLE or DONE.
- cut_zn, input, 1: ZN output of the CUT.
- A1, output, 1: CUT input, bit 3 of the pattern index.
- A2, output, 1: CUT input, bit 2 of the pattern index.
- B1, output, 1: CUT input, bit 1 of the pattern index.
- B2, output, 1: CUT input, bit 0 of the pattern index.
- busy, output, 1: run in progress.
- done, output, 1: run complete; results valid.
- pass, output, 1: done and err_count == 0.
- err_count, output, 5: number of mismatching patterns, 0..16.
- first_fail_valid, output, 1: at least one mismatch recorded this run.
- first_fail_idx, output, 4: pattern index of the first mismatch.
- obs_valid, output, 1: one-cycle pulse for each sampled pattern.
- obs_idx, output, 4: pattern index just sampled.
- obs_zn, output, 1: sampled cut_zn value.
- obs_mismatch, output, 1: sampled value differs from expected.

Behaviour:
- Clock and reset: one clock CK. Reset is synchronous and active-low on RN.
- Reset values (RN=0 at an edge): state IDLE; A1/A2/B1/B2=0; busy=0, done=0, pass=0; err_count=0; first_fail_valid=0, first_fail_idx=0; obs_valid=0, obs_idx=0, obs_zn=0, obs_mismatch=0. Reset takes priority over every other event, including mid-run; no partial results are retained.
- All outputs are registered.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Pattern outputs = 0000.
  - On an edge with start=1: go to RUN; idx=0; settle counter=0; err_count=0; first_fail_valid=0; first_fail_idx=0; busy=1.
- RUN:
  - Pattern idx is driven on A1..B2 for exactly SETTLE_CYCLES+1 cycles.
  - The counter increments each edge. On the edge where counter == SETTLE_CYCLES, cut_zn is sampled and compared to TRUTH_TABLE[idx].
  - On that same edge: obs_valid=1 with obs_idx=idx, obs_zn=cut_zn, obs_mismatch=(cut_zn != expected).
  - On mismatch: err_count+1. If first_fail_valid=0, also set first_fail_idx=idx and first_fail_valid=1.
  - On that same edge, if idx<15: idx+1, counter=0, next pattern loaded.
  - On that same edge, if idx=15: go to DONE with busy=0, done=1, pass=(final err_count==0). Final err_count includes this sample.
  - obs_valid is 0 on all other edges.
- Latency: done rises 16*(SETTLE_CYCLES+1) edges after the start-accept edge (48 for the default). Exactly 16 obs_valid pulses per run.
- start during RUN: ignored. No restart; results are unaffected.
- DONE:
  - Results, done and pass are held. Pattern outputs return to 0000.
  - start=1 restarts exactly as from IDLE. done and pass clear on that edge; results clear.
- X/Z on cut_zn counts as a mismatch in simulation. The comparison uses case inequality; obs_zn reflects the sampled value.
- err_count maximum is 16. The 5-bit field never wraps.

Test Plan:
1. Default parameters, behavioural AOI22 connected, 1-cycle start pulse.
   - Required: obs_zn sequence idx0..15 = 1,1,1,0,1,1,1,0,1,1,1,0,0,0,0,0.
   - Required: done=1 exactly 48 edges after the start-accept edge; pass=1; err_count=0; first_fail_valid=0.
2. cut_zn tied to 1 (stuck-at-1).
   - Required: err_count=7 (idx 3,7,11,12,13,14,15); first_fail_idx=3; first_fail_valid=1; pass=0; obs_mismatch high on exactly those 7 pulses.
3. cut_zn tied to 0 (stuck-at-0).
   - Required: err_count=9; first_fail_idx=0; pass=0.
4. Pulse start again 20 edges into a run, then pulse start in DONE.
   - Required: the first run completes at edge 48 with unchanged results.
   - Required: the DONE start clears done/pass/err_count on the accept edge, and a fresh run completes 48 edges later.
5. RN driven low for one edge, 25 edges into a stuck-at-1 run.
   - Required: all outputs reach reset values on that edge; no done pulse follows.
   - Required: a subsequent start gives a complete run with err_count=7.
6. SETTLE_CYCLES=1, CUT modelled as AOI22 followed by a 1-cycle register.
   - Required: done at edge 32, pass=1.
   - Required: the same CUT with a 2-cycle delay gives pass=0 and err_count>0.
